// File: rtl/dbg_run_ctrl_if.sv
// Command, breakpoint-table and status signals between the debug front end and
// the run controller.
interface dbg_run_ctrl_if #(
  parameter int unsigned NBRK = 4,
  parameter int unsigned AW   = 32
);
  localparam int unsigned IW = $clog2(NBRK);

  logic          step;
  logic          cont;
  logic          halt;
  logic [7:0]    step_cnt;
  logic          brk_we;
  logic [IW-1:0] brk_idx;
  logic [AW-1:0] brk_addr;
  logic          brk_en;
  logic          brk_clr_all;
  logic          cnt_clr;
  logic [AW-1:0] pc;
  logic          cpu_en;
  logic          pause;
  logic [1:0]    mode;
  logic          brk_hit;
  logic [IW-1:0] brk_hit_idx;
  logic [31:0]   run_cycles;

  modport master (
    output step, cont, halt, step_cnt, brk_we, brk_idx, brk_addr, brk_en, brk_clr_all,
           cnt_clr, pc,
    input  cpu_en, pause, mode, brk_hit, brk_hit_idx, run_cycles
  );

  modport slave (
    input  step, cont, halt, step_cnt, brk_we, brk_idx, brk_addr, brk_en, brk_clr_all,
           cnt_clr, pc,
    output cpu_en, pause, mode, brk_hit, brk_hit_idx, run_cycles
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Debug run-mode controller: turns step/cont/halt pulses and PC breakpoints
// into a per-cycle CPU clock enable.
module dbg_run_ctrl #(
  parameter int unsigned NBRK = 4,
  parameter int unsigned AW   = 32
) (
  input logic           clk,
  input logic           rstn,
  dbg_run_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(NBRK);

  typedef enum logic [1:0] {
    StPause = 2'b00,
    StStep  = 2'b01,
    StCont  = 2'b10
  } state_e;

  state_e        state_q;
  logic [7:0]    step_left_q;
  logic          skip_q;
  logic          brk_hit_q;
  logic [IW-1:0] brk_hit_idx_q;
  logic [NBRK-1:0] brk_valid_q;
  logic [AW-1:0] brk_addr_q [NBRK];
  logic [31:0]   run_cycles_q;

  logic          match;
  logic [IW-1:0] match_idx;
  logic          stop_brk;
  logic          cpu_en;

  // Scan from the top so the lowest matching slot wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NBRK - 1; i >= 0; i--) begin
      if (brk_valid_q[i] && (brk_addr_q[i] == bus.pc)) begin
        match     = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  assign stop_brk = match && !skip_q;
  assign cpu_en   = (state_q != StPause) && !stop_brk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StPause;
      step_left_q   <= 8'd0;
      skip_q        <= 1'b0;
      brk_hit_q     <= 1'b0;
      brk_hit_idx_q <= '0;
    end else begin
      // skip only shields the first executed instruction after a resume.
      if (cpu_en) skip_q <= 1'b0;
      case (state_q)
        StPause: begin
          if (bus.cont) begin
            state_q   <= StCont;
            skip_q    <= 1'b1;
            brk_hit_q <= 1'b0;
          end else if (bus.step) begin
            state_q     <= StStep;
            step_left_q <= (bus.step_cnt == 8'd0) ? 8'd1 : bus.step_cnt;
            skip_q      <= 1'b1;
            brk_hit_q   <= 1'b0;
          end
        end
        StStep: begin
          if (stop_brk) begin
            state_q       <= StPause;
            brk_hit_q     <= 1'b1;
            brk_hit_idx_q <= match_idx;
          end else if (bus.halt) begin
            state_q <= StPause;
          end else begin
            step_left_q <= step_left_q - 8'd1;
            if (step_left_q == 8'd1) state_q <= StPause;
          end
        end
        StCont: begin
          if (stop_brk) begin
            state_q       <= StPause;
            brk_hit_q     <= 1'b1;
            brk_hit_idx_q <= match_idx;
          end else if (bus.halt) begin
            state_q <= StPause;
          end
        end
        default: state_q <= StPause;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      brk_valid_q <= '0;
      for (int i = 0; i < NBRK; i++) brk_addr_q[i] <= '0;
    end else if (bus.brk_clr_all) begin
      brk_valid_q <= '0;
    end else if (bus.brk_we) begin
      brk_valid_q[bus.brk_idx] <= bus.brk_en;
      brk_addr_q[bus.brk_idx]  <= bus.brk_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cycles_q <= 32'd0;
    end else if (bus.cnt_clr) begin
      run_cycles_q <= 32'd0;
    end else if (cpu_en) begin
      run_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.pause       = (state_q == StPause);
  assign bus.mode        = state_q;
  assign bus.brk_hit     = brk_hit_q;
  assign bus.brk_hit_idx = brk_hit_idx_q;
  assign bus.run_cycles  = run_cycles_q;
endmodule
